// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, 2-entry fetch buffer feeding decode, redirect and HALT handling.
// Reads a combinational instruction memory; the fetched word is captured on the same edge.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]            HALT_OPCODE = 5'b00000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  output logic                  imem_wr,
  input  logic [15:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [15:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_next_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  halted,
  output logic                  err
);

  typedef struct packed {
    logic [15:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t [1:0]          fifo;
  entry_t                new_entry;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pop;
  logic                  fetch;

  assign valid_out = (count != 2'd0);
  assign pop       = valid_out & ready_in;
  // A full buffer can still fetch when the head leaves on the same edge.
  assign fetch     = !rst & !halted & !redirect_valid & ((count != 2'd2) | pop);
  assign new_entry = '{instr: imem_data, pc: pc};

  assign imem_en   = fetch;
  assign imem_addr = rst ? RESET_PC : pc;
  assign imem_wr   = 1'b0;

  // Outputs read as zero whenever the head is empty, matching the reset state.
  assign instr_out   = valid_out ? fifo[0].instr : 16'h0000;
  assign pc_out      = valid_out ? fifo[0].pc : '0;
  assign pc_next_out = valid_out ? fifo[0].pc + ADDR_WIDTH'(2) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      fifo   <= '0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else if (redirect_valid) begin
      count  <= 2'd0;
      pc     <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      halted <= 1'b0;
      if (redirect_pc[0]) err <= 1'b1;
    end else begin
      if (fetch) begin
        pc <= pc + ADDR_WIDTH'(2);
        if (imem_data[15:11] == HALT_OPCODE) halted <= 1'b1;
      end
      case ({fetch, pop})
        2'b10: begin
          if (count == 2'd0) fifo[0] <= new_entry;
          else               fifo[1] <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo[0] <= fifo[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo[0] <= new_entry;
          end else begin
            fifo[0] <= fifo[1];
            fifo[1] <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line, HALT, backpressure, redirect, wrap and reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] pc_next_out;
  logic        valid_out;
  logic        ready_in;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_wr(imem_wr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_out(pc_out), .pc_next_out(pc_next_out),
    .valid_out(valid_out), .ready_in(ready_in), .halted(halted), .err(err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Default words have opcode != HALT so only the planted 0x0000 stops fetch.
    for (int i = 0; i < 32768; i++) mem[i] = 16'h8000 | 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h0000;

    rst = 1'b1; ready_in = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    tick();
    tick();
    chk("rst_en",      {15'd0, imem_en}, 16'd0);
    chk("rst_addr",    imem_addr, 16'h0000);
    chk("rst_valid",   {15'd0, valid_out}, 16'd0);
    chk("rst_halted",  {15'd0, halted}, 16'd0);
    chk("rst_err",     {15'd0, err}, 16'd0);
    chk("rst_instr",   instr_out, 16'h0000);
    chk("rst_pc",      pc_out, 16'h0000);
    chk("rst_pcnext",  pc_next_out, 16'h0000);

    // Straight-line run
    rst = 1'b0; #1;
    chk("sl_en0",   {15'd0, imem_en}, 16'd1);
    chk("sl_addr0", imem_addr, 16'h0000);
    tick();
    chk("sl_valid1", {15'd0, valid_out}, 16'd1);
    chk("sl_instr1", instr_out, 16'h1111);
    chk("sl_pc1",    pc_out, 16'h0000);
    chk("sl_next1",  pc_next_out, 16'h0002);
    tick();
    chk("sl_instr2", instr_out, 16'h2222);
    chk("sl_pc2",    pc_out, 16'h0002);
    tick();
    chk("sl_instr3", instr_out, 16'h3333);
    chk("sl_pc3",    pc_out, 16'h0004);
    chk("sl_addr3",  imem_addr, 16'h0006);
    chk("sl_wr",     {15'd0, imem_wr}, 16'd0);

    // HALT at address 6
    tick();
    chk("h_instr",  instr_out, 16'h0000);
    chk("h_pc",     pc_out, 16'h0006);
    chk("h_valid",  {15'd0, valid_out}, 16'd1);
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_en",     {15'd0, imem_en}, 16'd0);
    tick();
    chk("h_drain_valid", {15'd0, valid_out}, 16'd0);
    chk("h_en2",         {15'd0, imem_en}, 16'd0);
    chk("h_addr",        imem_addr, 16'h0008);
    redirect_valid = 1'b1; redirect_pc = 16'h0010; #1;
    chk("h_redir_en", {15'd0, imem_en}, 16'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("h_resume_halted", {15'd0, halted}, 16'd0);
    chk("h_resume_valid",  {15'd0, valid_out}, 16'd0);
    chk("h_resume_en",     {15'd0, imem_en}, 16'd1);
    chk("h_resume_addr",   imem_addr, 16'h0010);
    tick();
    chk("h_resume_instr", instr_out, 16'h8008);
    chk("h_resume_pc",    pc_out, 16'h0010);

    // Backpressure: restart at 0 with decode stalled
    ready_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("bp_valid0", {15'd0, valid_out}, 16'd0);
    chk("bp_addr0",  imem_addr, 16'h0000);
    tick();
    chk("bp_instr1", instr_out, 16'h1111);
    chk("bp_en1",    {15'd0, imem_en}, 16'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_instr", instr_out, 16'h1111);
      chk("bp_hold_pc",    pc_out, 16'h0000);
      chk("bp_hold_en",    {15'd0, imem_en}, 16'd0);
      chk("bp_hold_addr",  imem_addr, 16'h0004);
    end
    ready_in = 1'b1; #1;
    chk("bp_release_en", {15'd0, imem_en}, 16'd1);
    tick();
    chk("bp_instr2", instr_out, 16'h2222);
    chk("bp_pc2",    pc_out, 16'h0002);
    tick();
    chk("bp_instr3",  instr_out, 16'h3333);
    chk("bp_pc3",     pc_out, 16'h0004);
    chk("bp_halted",  {15'd0, halted}, 16'd1);

    // Redirect with two entries buffered (3333 and HALT)
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0; #1;
    chk("rd_valid",  {15'd0, valid_out}, 16'd0);
    chk("rd_halted", {15'd0, halted}, 16'd0);
    chk("rd_addr",   imem_addr, 16'h0040);
    chk("rd_en",     {15'd0, imem_en}, 16'd1);
    tick();
    chk("rd_instr", instr_out, 16'h8020);
    chk("rd_pc",    pc_out, 16'h0040);
    chk("rd_next",  pc_next_out, 16'h0042);

    // Misaligned redirect and PC wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0; #1;
    chk("mis_err",   {15'd0, err}, 16'd1);
    chk("mis_addr",  imem_addr, 16'hFFFE);
    chk("mis_valid", {15'd0, valid_out}, 16'd0);
    tick();
    chk("wrap_instr0", instr_out, 16'hFFFF);
    chk("wrap_pc0",    pc_out, 16'hFFFE);
    chk("wrap_next0",  pc_next_out, 16'h0000);
    tick();
    chk("wrap_instr1", instr_out, 16'h1111);
    chk("wrap_pc1",    pc_out, 16'h0000);
    chk("wrap_next1",  pc_next_out, 16'h0002);
    chk("wrap_err",    {15'd0, err}, 16'd1);

    // Reset mid-stream with the buffer full
    ready_in = 1'b0;
    tick();
    chk("mr_full_instr", instr_out, 16'h1111);
    chk("mr_full_en",    {15'd0, imem_en}, 16'd0);
    rst = 1'b1; #1;
    chk("mr_en_in_rst",   {15'd0, imem_en}, 16'd0);
    chk("mr_addr_in_rst", imem_addr, 16'h0000);
    tick();
    chk("mr_valid",  {15'd0, valid_out}, 16'd0);
    chk("mr_halted", {15'd0, halted}, 16'd0);
    chk("mr_err",    {15'd0, err}, 16'd0);
    chk("mr_instr",  instr_out, 16'h0000);
    rst = 1'b0; ready_in = 1'b1; #1;
    chk("mr_restart_en",   {15'd0, imem_en}, 16'd1);
    chk("mr_restart_addr", imem_addr, 16'h0000);
    tick();
    chk("mr_restart_instr", instr_out, 16'h1111);
    chk("mr_restart_pc",    pc_out, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
